divisor_sequencial: RTL and testbench

Sequential unsigned restoring divider for the MIPS_CPU datapath: the inverse unit of the 16x16 shift-add multiplier, serving DIVU. Divides a 32-bit dividend by a 16-bit divisor, one quotient bit per clock. It exposes the same start/Idle/Done handshake as the multiplier, so the control unit drives both units identically.

---
 rtl/divisor_sequencial.sv | 103 ++++++++++
 tb/tb_divisor_sequencial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider (DW/VW), one quotient bit per clock.
// Same start/Idle/Done handshake as the shift-add multiplier.
module divisor_sequencial #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividendo,
  input  logic [VW-1:0] divisor,
  output logic          Idle,
  output logic          Done,
  output logic [DW-1:0] quociente,
  output logic [VW-1:0] resto,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic [VW-1:0] d;
  logic [CW-1:0] cnt;

  logic [VW:0]   t;
  logic          ge;
  logic [VW-1:0] diff;
  logic [VW-1:0] rnext;
  logic [DW-1:0] qnext;

  // The stored remainder is always < D, so its extra bit is implicit zero;
  // only the shifted trial value needs VW+1 bits, and T-D always fits VW bits.
  always_comb begin
    t     = {r, q[DW-1]};
    ge    = (t >= {1'b0, d});
    diff  = t[VW-1:0] - d;
    rnext = ge ? diff : t[VW-1:0];
    qnext = {q[DW-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= IDLE;
      Idle      <= 1'b1;
      Done      <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q    <= dividendo;
            d    <= divisor;
            r    <= '0;
            Idle <= 1'b0;
            if (divisor != '0) begin
              cnt   <= CW'(DW);
              state <= CALC;
            end else begin
              quociente <= '1;
              resto     <= dividendo[VW-1:0];
              div_zero  <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        CALC: begin
          q   <= qnext;
          r   <= rnext;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quociente <= qnext;
            resto     <= rnext;
            div_zero  <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Idle  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Idle  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed self-checking bench for divisor_sequencial: latency, results,
// divide-by-zero, start held high and mid-operation reset.
module tb_divisor_sequencial;

  logic        clock;
  logic        rst;
  logic        start;
  logic [31:0] dividendo;
  logic [15:0] divisor;
  logic        Idle;
  logic        Done;
  logic [31:0] quociente;
  logic [15:0] resto;
  logic        div_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  divisor_sequencial #(.DW(32), .VW(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .Idle      (Idle),
    .Done      (Done),
    .quociente (quociente),
    .resto     (resto),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launches one division and checks latency (samples after the accepting
  // edge, first sample = 1), results and the single-cycle Done pulse.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er, input logic ez,
                         input int elat, input bit chg);
    int lat;
    @(negedge clock);
    chk({tag, ".idle_before"}, 32'(Idle), 32'd1);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    while (lat <= 40) begin
      @(negedge clock);
      lat++;
      if (Done) break;
      if (chg && lat == 5) dividendo = 32'd9;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".idle_low"}, 32'(Idle), 32'd0);
    chk({tag, ".q"}, quociente, eq);
    chk({tag, ".r"}, 32'(resto), 32'(er));
    chk({tag, ".dz"}, 32'(div_zero), 32'(ez));
    @(negedge clock);
    chk({tag, ".done_fall"}, 32'(Done), 32'd0);
    chk({tag, ".idle_back"}, 32'(Idle), 32'd1);
    chk({tag, ".q_held"}, quociente, eq);
  endtask

  initial begin
    int t1;
    int t2;
    int k;
    bit seen;
    rst = 1'b0;
    start = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    chk("rst.idle", 32'(Idle), 32'd1);
    chk("rst.done", 32'(Done), 32'd0);
    chk("rst.q", quociente, 32'd0);
    chk("rst.r", 32'(resto), 32'd0);
    chk("rst.dz", 32'(div_zero), 32'd0);

    run_div("basic", 32'd8006001, 16'd4001, 32'd2001, 16'd0, 1'b0, 33, 1'b0);
    run_div("rem_chg", 32'd1035, 16'd22, 32'd47, 16'd1, 1'b0, 33, 1'b1);
    run_div("max_1", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 33, 1'b0);
    run_div("max_max", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 33, 1'b0);
    run_div("small", 32'd5, 16'd7, 32'd0, 16'd5, 1'b0, 33, 1'b0);
    run_div("dz", 32'd100, 16'd0, 32'hFFFF_FFFF, 16'd100, 1'b1, 1, 1'b0);
    run_div("after_dz", 32'd10, 16'd3, 32'd3, 16'd1, 1'b0, 33, 1'b0);

    // start held high: operands change during the first computation
    @(negedge clock);
    dividendo = 32'd8006001;
    divisor   = 16'd4001;
    start     = 1'b1;
    t1 = -1;
    k = 0;
    while (k < 50 && t1 < 0) begin
      @(negedge clock);
      k++;
      if (k == 3) begin dividendo = 32'd1035; divisor = 16'd22; end
      if (Done) t1 = cyc;
    end
    chk("hold.first_seen", 32'(t1 >= 0), 32'd1);
    chk("hold.q1", quociente, 32'd2001);
    chk("hold.r1", 32'(resto), 32'd0);
    t2 = -1;
    k = 0;
    while (k < 50 && t2 < 0) begin
      @(negedge clock);
      k++;
      if (Done) t2 = cyc;
    end
    chk("hold.spacing", 32'(t2 - t1), 32'd34);
    chk("hold.q2", quociente, 32'd47);
    chk("hold.r2", 32'(resto), 32'd1);
    start = 1'b0;
    repeat (40) @(negedge clock);

    // reset at step 10 of CALC
    dividendo = 32'd1035;
    divisor   = 16'd22;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1 rst = 1'b1;
    chk("abort.idle", 32'(Idle), 32'd1);
    chk("abort.done", 32'(Done), 32'd0);
    chk("abort.q", quociente, 32'd0);
    chk("abort.r", 32'(resto), 32'd0);
    chk("abort.dz", 32'(div_zero), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (Done) seen = 1'b1;
    end
    chk("abort.no_done", 32'(seen), 32'd0);
    run_div("fresh", 32'd8006001, 16'd4001, 32'd2001, 16'd0, 1'b0, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clock) begin
    if (Done && Idle) begin
      errors++;
      $display("FAIL idle_done_overlap: Done=%0b Idle=%0b required not both 1", Done, Idle);
    end
  end

endmodule
